// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared constants, field positions and fetch FSM encoding for the
//          5-stage RISC-V core front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int INSTR_W = 32;

  // addi x0,x0,0 : architectural no-op used as the pipeline bubble
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Source-register field positions in the base RV32 encoding
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [4:0] rs1_of(input logic [INSTR_W-1:0] instr);
    return instr[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [INSTR_W-1:0] instr);
    return instr[RS2_MSB:RS2_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : Program counter register with reset, load (redirect), hold and
//          +4 increment. Priority: reset > load > increment > hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_val,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // PC update; the +4 wraps naturally at 2^PC_W
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : IF stage plus IF/ID pipeline register. Holds the PC, drives the
//          instruction-memory address, captures the fetched word into IF/ID,
//          honours load-use stall and flushes on a taken branch.
//          Optional macro FETCH_PERF_CNT_EN adds stall/flush cycle counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int                            PC_W      = 32,
  parameter logic [PC_W-1:0]               RESET_PC  = '0,
  parameter logic [riscv_pkg::INSTR_W-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [PC_W-1:0]               branch_target,
  output logic [PC_W-1:0]               imem_addr,
  input  logic [riscv_pkg::INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]               IF_ID_pc,
  output logic [riscv_pkg::INSTR_W-1:0] IF_ID_instr,
  output logic                          IF_ID_valid,
  output logic [4:0]                    IF_ID_RS1,
  output logic [4:0]                    IF_ID_RS2,
  output logic                          target_misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   flush_cycles
`endif
);

  import riscv_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic                w_pc_load;
  logic                w_pc_inc;
  logic                w_ifid_flush;
  logic                w_ifid_load;
  logic                w_misalign_nxt;
  logic [PC_W-1:0]     w_pc;
  logic [PC_W-1:0]     w_target_aligned;

  logic [PC_W-1:0]     r_ifid_pc;
  logic [INSTR_W-1:0]  r_ifid_instr;
  logic                r_ifid_valid;
  logic                r_misalign;

  // Redirects always land on a word boundary; low bits only feed the flag
  assign w_target_aligned = {branch_target[PC_W-1:2], 2'b00};

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_pc_load),
    .i_load_val (w_target_aligned),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control; branch beats stall because the EX
  // instruction is older than the load-use pair being stalled
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_load      = 1'b0;
    w_pc_inc       = 1'b0;
    w_ifid_flush   = 1'b0;
    w_ifid_load    = 1'b0;
    w_misalign_nxt = 1'b0;
    case (r_state)
      S_BOOT: begin
        // one settling cycle for imem: PC and IF/ID hold
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (branch_taken) begin
          w_pc_load      = 1'b1;
          w_ifid_flush   = 1'b1;
          w_misalign_nxt = |branch_target[1:0];
        end else if (!stall) begin
          w_pc_inc    = 1'b1;
          w_ifid_load = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // IF/ID pipeline register and the registered misalignment pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= w_misalign_nxt;
      if (w_ifid_flush) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else if (w_ifid_load) begin
        r_ifid_pc    <= w_pc;
        r_ifid_instr <= imem_rdata;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign imem_addr       = w_pc;
  assign IF_ID_pc        = r_ifid_pc;
  assign IF_ID_instr     = r_ifid_instr;
  assign IF_ID_valid     = r_ifid_valid;
  assign target_misalign = r_misalign;

  // Bubbles must never look like a real source register to the hazard unit
  assign IF_ID_RS1 = r_ifid_valid ? rs1_of(r_ifid_instr) : 5'd0;
  assign IF_ID_RS2 = r_ifid_valid ? rs2_of(r_ifid_instr) : 5'd0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating stall/flush cycle counters, active only while running
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (stall && !branch_taken && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (branch_taken && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Scoreboard bench for fetch_stage. Directed stimulus pushes the
//          expected IF/ID view for each cycle; a negedge monitor pops and
//          compares. Perf-counter checks follow FETCH_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_pc, IF_ID_instr;
  logic        IF_ID_valid, target_misalign;
  logic [4:0]  IF_ID_RS1, IF_ID_RS2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
    logic        perf;
    logic [31:0] stc;
    logic [31:0] flc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction ROM: address 0 holds addi x1,x0,10; elsewhere an R-type
  // word whose rs1 = addr[6:2] and rs2 = ~addr[6:2]
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'h00A0_0093;
    return {7'h00, a[6:2] ^ 5'h1F, a[6:2], 3'b000, 5'd1, 7'h33};
  endfunction

  assign imem_rdata = rom(imem_addr);

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .IF_ID_pc        (IF_ID_pc),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_valid     (IF_ID_valid),
    .IF_ID_RS1       (IF_ID_RS1),
    .IF_ID_RS2       (IF_ID_RS2),
    .target_misalign (target_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare one expected record per cycle, away from the posedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] e_instr;
      logic [4:0]  e_rs1, e_rs2;
      e = exp_q.pop_front();
      e_instr = e.valid ? rom(e.pc) : NOP;
      e_rs1   = !e.valid ? 5'd0 : (e.pc == 32'd0) ? 5'd0  : e.pc[6:2];
      e_rs2   = !e.valid ? 5'd0 : (e.pc == 32'd0) ? 5'd10 : (e.pc[6:2] ^ 5'h1F);
      chk("imem_addr",       imem_addr,               e.addr);
      chk("IF_ID_valid",     32'(IF_ID_valid),        32'(e.valid));
      chk("IF_ID_instr",     IF_ID_instr,             e_instr);
      chk("IF_ID_RS1",       32'(IF_ID_RS1),          32'(e_rs1));
      chk("IF_ID_RS2",       32'(IF_ID_RS2),          32'(e_rs2));
      chk("target_misalign", 32'(target_misalign),    32'(e.mis));
      if (e.valid) chk("IF_ID_pc", IF_ID_pc, e.pc);
`ifdef FETCH_PERF_CNT_EN
      if (e.perf) begin
        chk("stall_cycles", stall_cycles, e.stc);
        chk("flush_cycles", flush_cycles, e.flc);
      end
`endif
    end
  end

  // One cycle: push what the outputs must show after this posedge, then
  // apply the inputs that act on the following posedge
  task automatic step_p(input logic rs, input logic st, input logic br, input logic [31:0] tg,
                        input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                        input logic em, input logic pf, input logic [31:0] sc,
                        input logic [31:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    e.addr = ea; e.valid = ev; e.pc = ep; e.mis = em;
    e.perf = pf; e.stc = sc; e.flc = fc;
    exp_q.push_back(e);
    reset = rs; stall = st; branch_taken = br; branch_target = tg;
  endtask

  task automatic step(input logic rs, input logic st, input logic br, input logic [31:0] tg,
                      input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                      input logic em);
    step_p(rs, st, br, tg, ea, ev, ep, em, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    //   rst st br target          addr          v  pc            mis
    step(1, 0, 0, 32'h0,          32'h0,         0, 32'h0,        0); // reset state
    step(0, 0, 0, 32'h0,          32'h0,         0, 32'h0,        0); // S_BOOT
    step(0, 0, 0, 32'h0,          32'h0,         0, 32'h0,        0); // first run cycle
    step(0, 0, 0, 32'h0,          32'h4,         1, 32'h0,        0); // valid rises
    step(0, 0, 0, 32'h0,          32'h8,         1, 32'h4,        0);
    step(0, 0, 0, 32'h0,          32'hC,         1, 32'h8,        0);
    // stall three cycles with PC at 0x10
    step(0, 1, 0, 32'h0,          32'h10,        1, 32'hC,        0);
    step(0, 1, 0, 32'h0,          32'h10,        1, 32'hC,        0);
    step(0, 1, 0, 32'h0,          32'h10,        1, 32'hC,        0);
    step(0, 0, 0, 32'h0,          32'h10,        1, 32'hC,        0);
    step(0, 0, 0, 32'h0,          32'h14,        1, 32'h10,       0); // 0x10 delivered once
    // taken branch to 0x40
    step(0, 0, 1, 32'h40,         32'h18,        1, 32'h14,       0);
    step(0, 0, 0, 32'h0,          32'h40,        0, 32'h0,        0); // bubble
    // branch and stall together, branch wins
    step(0, 1, 1, 32'h80,         32'h44,        1, 32'h40,       0);
    step(0, 0, 0, 32'h0,          32'h80,        0, 32'h0,        0);
    // misaligned target 0x42
    step(0, 0, 1, 32'h42,         32'h84,        1, 32'h80,       0);
    step(0, 0, 0, 32'h0,          32'h40,        0, 32'h0,        1); // pulse
    step(0, 0, 1, 32'hFFFF_FFFC,  32'h44,        1, 32'h40,       0); // pulse cleared
    // top-of-memory wrap
    step(0, 0, 0, 32'h0,          32'hFFFF_FFFC, 0, 32'h0,        0);
    step(0, 0, 0, 32'h0,          32'h0,         1, 32'hFFFF_FFFC,0);
    // reset in the middle of a stall
    step(0, 1, 0, 32'h0,          32'h4,         1, 32'h0,        0);
    step(1, 1, 0, 32'h0,          32'h4,         1, 32'h0,        0);
    step(0, 1, 0, 32'h0,          32'h0,         0, 32'h0,        0); // reset, S_BOOT
    step(0, 1, 0, 32'h0,          32'h0,         0, 32'h0,        0); // run, stalled
    step(0, 0, 0, 32'h0,          32'h0,         0, 32'h0,        0);
    // reset in the middle of a misaligned flush
    step(0, 0, 1, 32'h23,         32'h4,         1, 32'h0,        0);
    step(1, 0, 1, 32'h23,         32'h20,        0, 32'h0,        1);
    // counters: stall in S_BOOT is not counted, then 5 stalls and 2 flushes
    step_p(0, 1, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd0, 32'd0);
    step_p(0, 1, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd0, 32'd0);
    step_p(0, 1, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd1, 32'd0);
    step_p(0, 1, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd2, 32'd0);
    step_p(0, 1, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd3, 32'd0);
    step_p(0, 1, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd4, 32'd0);
    step_p(0, 0, 1, 32'h100, 32'h0,   0, 32'h0, 0, 1, 32'd5, 32'd0);
    step_p(0, 1, 1, 32'h200, 32'h100, 0, 32'h0, 0, 1, 32'd5, 32'd1);
    step_p(1, 0, 0, 32'h0,   32'h200, 0, 32'h0, 0, 1, 32'd5, 32'd2);
    step_p(0, 0, 0, 32'h0,   32'h0,   0, 32'h0, 0, 1, 32'd0, 32'd0); // cleared by reset

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
